qoa_sample_encoder: RTL

Streaming QOA (Quite OK Audio) sample encoder: the transmit-side counterpart of the chip's QOA decode datapath. It takes 16-bit signed PCM samples plus a host-chosen 4-bit scalefactor, runs the standard QOA 4-tap LMS predictor, and emits one 3-bit residual code per sample. It also emits the reconstructed sample, which is bit-identical to what the decoder will produce. It sits between the host-side sample source and the slice/frame packer.

---
 rtl/qoa_sample_encoder.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qoa_sample_encoder.sv
// QOA sample encoder: 4-tap LMS prediction, residual quantisation and
// reconstruction, one sample every eight cycles through a sequential FSM.
module qoa_sample_encoder #(
    parameter int WEIGHT_SHIFT = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lms_wr,
    input  logic [2:0]  lms_sel,
    input  logic [15:0] lms_wdata,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_sample,
    input  logic [3:0]  s_sf,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [2:0]  m_code,
    output logic [15:0] m_recon
);

    typedef enum logic [2:0] {
        IDLE, MAC0, MAC1, MAC2, MAC3, QUANT, UPDATE, OUT
    } state_t;

    state_t state, state_nxt;

    logic signed [15:0] hist [4];
    logic signed [15:0] weight [4];
    logic signed [15:0] hist_eff [4];
    logic signed [15:0] weight_eff [4];

    logic signed [15:0] sample_q;
    logic [3:0]         sf_q;
    logic signed [33:0] acc;
    logic signed [33:0] pred_q;
    logic [2:0]         code_q;

    logic               snap_en;
    logic [2:0]         snap_sel;
    logic signed [15:0] snap_val;

    function automatic logic [11:0] sf_lut(input logic [3:0] i);
        case (i)
            4'd0:  sf_lut = 12'd1;
            4'd1:  sf_lut = 12'd7;
            4'd2:  sf_lut = 12'd21;
            4'd3:  sf_lut = 12'd45;
            4'd4:  sf_lut = 12'd84;
            4'd5:  sf_lut = 12'd138;
            4'd6:  sf_lut = 12'd211;
            4'd7:  sf_lut = 12'd304;
            4'd8:  sf_lut = 12'd421;
            4'd9:  sf_lut = 12'd562;
            4'd10: sf_lut = 12'd731;
            4'd11: sf_lut = 12'd928;
            4'd12: sf_lut = 12'd1157;
            4'd13: sf_lut = 12'd1419;
            4'd14: sf_lut = 12'd1715;
            default: sf_lut = 12'd2048;
        endcase
    endfunction

    function automatic logic [16:0] recip_lut(input logic [3:0] i);
        case (i)
            4'd0:  recip_lut = 17'd65536;
            4'd1:  recip_lut = 17'd9363;
            4'd2:  recip_lut = 17'd3121;
            4'd3:  recip_lut = 17'd1457;
            4'd4:  recip_lut = 17'd781;
            4'd5:  recip_lut = 17'd475;
            4'd6:  recip_lut = 17'd311;
            4'd7:  recip_lut = 17'd216;
            4'd8:  recip_lut = 17'd156;
            4'd9:  recip_lut = 17'd117;
            4'd10: recip_lut = 17'd90;
            4'd11: recip_lut = 17'd71;
            4'd12: recip_lut = 17'd57;
            4'd13: recip_lut = 17'd47;
            4'd14: recip_lut = 17'd39;
            default: recip_lut = 17'd32;
        endcase
    endfunction

    // Dequant magnitudes scaled by 4: 0.75, 2.5, 4.5, 7.
    function automatic logic [4:0] base_lut(input logic [1:0] i);
        case (i)
            2'd0:    base_lut = 5'd3;
            2'd1:    base_lut = 5'd10;
            2'd2:    base_lut = 5'd18;
            default: base_lut = 5'd28;
        endcase
    endfunction

    function automatic logic signed [1:0] sgn(input logic signed [35:0] x);
        if (x > 36'sd0)
            sgn = 2'sd1;
        else if (x < 36'sd0)
            sgn = -2'sd1;
        else
            sgn = 2'sd0;
    endfunction

    // A write accepted alongside a sample must not be seen by that sample,
    // so the overwritten value is kept and substituted until UPDATE.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            hist_eff[i]   = hist[i];
            weight_eff[i] = weight[i];
            if (snap_en && snap_sel == {1'b0, 2'(i)})
                hist_eff[i] = snap_val;
            if (snap_en && snap_sel == {1'b1, 2'(i)})
                weight_eff[i] = snap_val;
        end
    end

    logic [1:0]         mac_idx;
    logic signed [31:0] mac_prod;

    always_comb begin
        case (state)
            MAC1:    mac_idx = 2'd1;
            MAC2:    mac_idx = 2'd2;
            MAC3:    mac_idx = 2'd3;
            default: mac_idx = 2'd0;
        endcase
        mac_prod = 32'(hist_eff[mac_idx]) * 32'(weight_eff[mac_idx]);
    end

    logic signed [33:0] pred_c;
    logic signed [34:0] r_full;
    logic signed [17:0] r_sat;
    logic signed [35:0] div_prod;
    logic signed [35:0] n_raw;
    logic signed [35:0] n_adj;
    logic signed [4:0]  n_c;
    logic [4:0]         q_idx;
    logic [2:0]         code_c;

    always_comb begin
        pred_c = acc >>> WEIGHT_SHIFT;
        r_full = 35'(sample_q) - 35'(pred_c);
        if (r_full > 35'sd131071)
            r_sat = 18'sh1FFFF;
        else if (r_full < -35'sd131072)
            r_sat = 18'sh20000;
        else
            r_sat = r_full[17:0];
        div_prod = 36'(r_sat) * $signed({19'd0, recip_lut(sf_q)});
        n_raw    = (div_prod + 36'sd32768) >>> 16;
        n_adj    = n_raw + 36'(sgn(36'(r_sat))) - 36'(sgn(n_raw));
        if (n_adj > 36'sd8)
            n_c = 5'sd8;
        else if (n_adj < -36'sd8)
            n_c = -5'sd8;
        else
            n_c = n_adj[4:0];
        q_idx = n_c + 5'sd8;
        case (q_idx)
            5'd0, 5'd1, 5'd2:    code_c = 3'd7;
            5'd3, 5'd4:          code_c = 3'd5;
            5'd5, 5'd6:          code_c = 3'd3;
            5'd7:                code_c = 3'd1;
            5'd10, 5'd11:        code_c = 3'd2;
            5'd12, 5'd13:        code_c = 3'd4;
            5'd14, 5'd15, 5'd16: code_c = 3'd6;
            default:             code_c = 3'd0;
        endcase
    end

    logic [16:0]        dq_mag_full;
    logic signed [15:0] dq;
    logic signed [34:0] recon_full;
    logic signed [15:0] recon_c;
    logic signed [15:0] delta;

    always_comb begin
        dq_mag_full = 17'(sf_lut(sf_q)) * 17'(base_lut(code_q[2:1])) + 17'd2;
        dq = code_q[0] ? -$signed({1'b0, dq_mag_full[16:2]})
                       :  $signed({1'b0, dq_mag_full[16:2]});
        recon_full = 35'(pred_q) + 35'(dq);
        if (recon_full > 35'sd32767)
            recon_c = 16'sh7FFF;
        else if (recon_full < -35'sd32768)
            recon_c = 16'sh8000;
        else
            recon_c = recon_full[15:0];
        delta = dq >>> 4;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = MAC0;
            MAC0:    state_nxt = MAC1;
            MAC1:    state_nxt = MAC2;
            MAC2:    state_nxt = MAC3;
            MAC3:    state_nxt = QUANT;
            QUANT:   state_nxt = UPDATE;
            UPDATE:  state_nxt = OUT;
            OUT:     if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        s_ready = (state == IDLE) && rst_n;
        m_valid = (state == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hist[i]   <= '0;
                weight[i] <= '0;
            end
            sample_q <= '0;
            sf_q     <= '0;
            acc      <= '0;
            pred_q   <= '0;
            code_q   <= '0;
            snap_en  <= 1'b0;
            snap_sel <= '0;
            snap_val <= '0;
            m_code   <= '0;
            m_recon  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        sample_q <= s_sample;
                        sf_q     <= s_sf;
                        acc      <= '0;
                        snap_en  <= lms_wr;
                        snap_sel <= lms_sel;
                        snap_val <= lms_sel[2] ? weight[lms_sel[1:0]] : hist[lms_sel[1:0]];
                    end
                    if (lms_wr) begin
                        if (lms_sel[2])
                            weight[lms_sel[1:0]] <= lms_wdata;
                        else
                            hist[lms_sel[1:0]] <= lms_wdata;
                    end
                end
                MAC0, MAC1, MAC2, MAC3: acc <= acc + 34'(mac_prod);
                QUANT: begin
                    pred_q <= pred_c;
                    code_q <= code_c;
                end
                UPDATE: begin
                    for (int unsigned i = 0; i < 4; i++)
                        weight[i] <= weight[i] + (hist_eff[i][15] ? -delta : delta);
                    for (int unsigned i = 0; i < 3; i++)
                        hist[i] <= hist[i+1];
                    hist[3] <= recon_c;
                    m_code  <= code_q;
                    m_recon <= recon_c;
                    snap_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
